// File: rtl/rd_port_arbi.sv
// rtl/rd_port_arbi.sv - shared memory read-port arbiter/sequencer; optional starve guard via RD_ARBI_STARVE_GUARD_EN
module rd_port_arbi #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef RD_ARBI_STARVE_GUARD_EN
  , parameter int STARVE_MAX = 4
`endif
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_src,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_src;
  logic                r_kill;
  logic                r_if_rvalid;
  logic                r_dm_rvalid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;

  logic w_if_ok;
  logic w_force_if;
  logic w_grant_dm;
  logic w_grant_if;
  logic w_kill_now;

  // A flushed fetch is not a candidate for a grant in the same cycle.
  assign w_if_ok    = if_req & ~if_flush;
  assign w_grant_dm = dm_req & ~w_force_if;
  assign w_grant_if = ~w_grant_dm & w_if_ok;
  // Kill covers a flush arriving in the very cycle the data comes back.
  assign w_kill_now = r_kill | (if_flush & ~r_mem_src);

`ifdef RD_ARBI_STARVE_GUARD_EN
  localparam logic [2:0] LP_STARVE_MAX = 3'(STARVE_MAX);

  logic [2:0] r_starve;

  assign w_force_if = w_if_ok & (r_starve == LP_STARVE_MAX);

  // Count data grants made over a waiting fetch; saturate rather than wrap.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_starve <= 3'd0;
    end else if (r_state == S_IDLE) begin
      if (!if_req || w_grant_if) begin
        r_starve <= 3'd0;
      end else if (w_grant_dm && w_if_ok && (r_starve != 3'd7)) begin
        r_starve <= r_starve + 3'd1;
      end
    end
  end
`else
  assign w_force_if = 1'b0;
`endif

  // Transaction sequencer: grant, port handshake, data capture, one-cycle response.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_src   <= 1'b0;
      r_kill      <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_kill <= 1'b0;
          if (w_grant_dm) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= dm_addr;
            r_mem_src  <= 1'b1;
            r_state    <= S_REQ;
          end else if (w_grant_if) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= if_addr;
            r_mem_src  <= 1'b0;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          r_kill <= w_kill_now;
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_kill <= w_kill_now;
          if (mem_rvalid) begin
            r_state <= S_RESP;
            if (!w_kill_now) begin
              if (r_mem_src) begin
                r_dm_rvalid <= 1'b1;
                r_dm_rdata  <= mem_rdata;
              end else begin
                r_if_rvalid <= 1'b1;
                r_if_rdata  <= mem_rdata;
              end
            end
          end
        end
        S_RESP: begin
          r_kill  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_src   = r_mem_src;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign dm_rvalid = r_dm_rvalid;
  assign dm_rdata  = r_dm_rdata;

endmodule

// File: tb/tb_rd_port_arbi.sv
// tb/tb_rd_port_arbi.sv - scoreboard bench for rd_port_arbi
module tb_rd_port_arbi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic [31:0] dm_addr = '0;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_src;
  logic        mem_ack = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  rd_port_arbi dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_flush    (if_flush),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .dm_req      (dm_req),
    .dm_addr     (dm_addr),
    .dm_rvalid   (dm_rvalid),
    .dm_rdata    (dm_rdata),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_src     (mem_src),
    .mem_ack     (mem_ack),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  typedef struct packed {
    logic        src;
    logic [31:0] val;
  } exp_t;

  exp_t grant_q[$];
  exp_t resp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ack_dly = 0;
  int rv_dly = 0;
  int if_pulses = 0;
  int dm_pulses = 0;
  int resp_seq = 0;
  int last_if_seq = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h1FC0_0000) ? 32'h3C08_0001 : (a ^ 32'hC3A5_5A3C);
  endfunction

  function automatic void exp_grant(input logic src, input logic [31:0] a);
    grant_q.push_back({src, a});
  endfunction

  function automatic void exp_resp(input logic src, input logic [31:0] d);
    resp_q.push_back({src, d});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // memory side: ack after ack_dly cycles, data after rv_dly more; grants checked at ack
  initial begin : mem_model
    int   m_state;
    int   m_cnt;
    logic [31:0] m_addr;
    exp_t g;
    m_state = 0;
    m_cnt = 0;
    m_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst_n) begin
        m_state = 0;
        m_cnt = 0;
      end else if (m_state == 0) begin
        if (mem_req) begin
          if (m_cnt >= ack_dly) begin
            mem_ack = 1'b1;
            m_addr = mem_addr;
            m_state = 1;
            m_cnt = 0;
            n_checks++;
            if (grant_q.size() == 0) begin
              n_fail++;
              $display("FAIL grant: unexpected grant src=%0b addr=%h", mem_src, mem_addr);
            end else begin
              g = grant_q.pop_front();
              if (mem_src !== g.src || mem_addr !== g.val) begin
                n_fail++;
                $display("FAIL grant: got src=%0b addr=%h, expected src=%0b addr=%h",
                         mem_src, mem_addr, g.src, g.val);
              end
            end
          end else begin
            m_cnt++;
          end
        end
      end else begin
        if (m_cnt >= rv_dly) begin
          mem_rvalid = 1'b1;
          mem_rdata = mem_data(m_addr);
          m_state = 0;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // response monitor: every rvalid pulse must match the head of the scoreboard
  always @(negedge clk) begin : resp_mon
    exp_t e;
    if (rst_n && (if_rvalid || dm_rvalid)) begin
      n_checks++;
      if (if_rvalid && dm_rvalid) begin
        n_fail++;
        $display("FAIL resp: if_rvalid and dm_rvalid both high");
      end else if (resp_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp: unexpected pulse if=%0b dm=%0b data=%h", if_rvalid, dm_rvalid,
                 dm_rvalid ? dm_rdata : if_rdata);
      end else begin
        e = resp_q.pop_front();
        if (e.src !== dm_rvalid || e.val !== (dm_rvalid ? dm_rdata : if_rdata)) begin
          n_fail++;
          $display("FAIL resp: got dm=%0b data=%h, expected dm=%0b data=%h", dm_rvalid,
                   dm_rvalid ? dm_rdata : if_rdata, e.src, e.val);
        end
      end
      if (if_rvalid) begin
        if_pulses++;
        last_if_seq = resp_seq;
      end
      if (dm_rvalid) dm_pulses++;
      resp_seq++;
    end
  end

  task automatic req_dm(input logic [31:0] a, output int lat);
    int t0;
    bit got;
    step();
    dm_req = 1'b1;
    dm_addr = a;
    t0 = cyc;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (dm_rvalid) got = 1'b1;
    end
    lat = got ? (cyc - t0) : -1;
    step();
    dm_req = 1'b0;
  endtask

  task automatic req_if(input logic [31:0] a, output int lat);
    int t0;
    bit got;
    step();
    if_req = 1'b1;
    if_addr = a;
    t0 = cyc;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (if_rvalid) got = 1'b1;
    end
    lat = got ? (cyc - t0) : -1;
    step();
    if_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0 || mem_src !== 1'b0 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_port: req=%b src=%b addr=%h, expected 0/0/0", mem_req, mem_src, mem_addr);
    end
    n_checks++;
    if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rvalid: if=%b dm=%b, expected 0/0", if_rvalid, dm_rvalid);
    end
    n_checks++;
    if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: if=%h dm=%h, expected 0/0", if_rdata, dm_rdata);
    end
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: mem_req=%b, expected 0", mem_req);
    end
  endtask

  task automatic test_lone_fetch();
    int  t0;
    int  lat;
    int  p_dm;
    bit  got;
    ack_dly = 0;
    rv_dly = 0;
    p_dm = dm_pulses;
    exp_grant(1'b0, 32'h1FC0_0000);
    exp_resp(1'b0, 32'h3C08_0001);
    step();
    if_req = 1'b1;
    if_addr = 32'h1FC0_0000;
    t0 = cyc;
    step();
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || mem_src !== 1'b0 || mem_addr !== 32'h1FC0_0000) begin
      n_fail++;
      $display("FAIL lone_grant: req=%b src=%b addr=%h, expected 1/0/1fc00000", mem_req, mem_src, mem_addr);
    end
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (if_rvalid) got = 1'b1;
    end
    lat = got ? (cyc - t0) : -1;
    n_checks++;
    if (lat !== 3 || if_rdata !== 32'h3C08_0001) begin
      n_fail++;
      $display("FAIL lone_latency: lat=%0d data=%h, expected 3 and 3c080001", lat, if_rdata);
    end
    step();
    if_req = 1'b0;
    n_checks++;
    if (dm_pulses !== p_dm) begin
      n_fail++;
      $display("FAIL lone_no_dm: dm pulses=%0d, expected %0d", dm_pulses, p_dm);
    end
  endtask

  task automatic test_simultaneous();
    int lat_d;
    int lat_i;
    ack_dly = 0;
    rv_dly = 0;
    exp_grant(1'b1, 32'h8000_1000);
    exp_grant(1'b0, 32'h0040_0000);
    exp_resp(1'b1, mem_data(32'h8000_1000));
    exp_resp(1'b0, mem_data(32'h0040_0000));
    fork
      req_dm(32'h8000_1000, lat_d);
      req_if(32'h0040_0000, lat_i);
    join
    n_checks++;
    if (lat_d !== 3 || lat_i !== 7) begin
      n_fail++;
      $display("FAIL simul_latency: dm=%0d if=%0d, expected 3 and 7", lat_d, lat_i);
    end
  endtask

  task automatic flush_case(input int off, input logic [31:0] a);
    int p_if;
    int lat;
    ack_dly = 0;
    rv_dly = 2;
    p_if = if_pulses;
    exp_grant(1'b0, a);
    step();
    if_req = 1'b1;
    if_addr = a;
    repeat (off) step();
    if_flush = 1'b1;
    if_req = 1'b0;
    step();
    if_flush = 1'b0;
    repeat (6) step();
    n_checks++;
    if (if_pulses !== p_if) begin
      n_fail++;
      $display("FAIL flush_off%0d_drop: if pulses=%0d, expected %0d", off, if_pulses, p_if);
    end
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_off%0d_idle: mem_req=%b, expected 0", off, mem_req);
    end
    rv_dly = 0;
    exp_grant(1'b0, 32'hBFC0_0010);
    exp_resp(1'b0, mem_data(32'hBFC0_0010));
    req_if(32'hBFC0_0010, lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL flush_off%0d_refetch: lat=%0d, expected 3", off, lat);
    end
  endtask

  task automatic test_flush();
    flush_case(3, 32'h0040_0100);
    flush_case(4, 32'h0040_0200);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    int lat;
    int a_d;
    int r_d;
    for (int k = 0; k < 6; k++) begin
      a_d = int'($urandom_range(0, 2));
      r_d = int'($urandom_range(0, 3));
      ack_dly = a_d;
      rv_dly = r_d;
      a = $urandom;
      exp_grant(k[0], a);
      exp_resp(k[0], mem_data(a));
      if (k[0]) req_dm(a, lat);
      else req_if(a, lat);
      n_checks++;
      if (lat !== 3 + a_d + r_d) begin
        n_fail++;
        $display("FAIL b2b_%0d_latency: lat=%0d, expected %0d", k, lat, 3 + a_d + r_d);
      end
    end
  endtask

  task automatic dm_burst(input int n, input logic [31:0] base);
    bit got;
    step();
    dm_req = 1'b1;
    dm_addr = base;
    for (int i = 0; i < n; i++) begin
      got = 1'b0;
      for (int j = 0; j < 300 && !got; j++) begin
        @(negedge clk);
        if (dm_rvalid) got = 1'b1;
      end
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("FAIL burst_timeout: beat %0d got=0, expected 1", i);
      end
      step();
      if (i < n - 1) dm_addr = base + 32'(4 * (i + 1));
      else dm_req = 1'b0;
    end
  endtask

  task automatic test_starve();
    int seq0;
    int lat_i;
    int exp_pos;
    ack_dly = 0;
    rv_dly = 0;
    seq0 = resp_seq;
`ifdef RD_ARBI_STARVE_GUARD_EN
    exp_pos = 4;
`else
    exp_pos = 6;
`endif
    for (int i = 0; i < 6; i++) begin
      if (i == exp_pos) begin
        exp_grant(1'b0, 32'h0040_0300);
        exp_resp(1'b0, mem_data(32'h0040_0300));
      end
      exp_grant(1'b1, 32'h8000_2000 + 32'(4 * i));
      exp_resp(1'b1, mem_data(32'h8000_2000 + 32'(4 * i)));
    end
    if (exp_pos == 6) begin
      exp_grant(1'b0, 32'h0040_0300);
      exp_resp(1'b0, mem_data(32'h0040_0300));
    end
    fork
      dm_burst(6, 32'h8000_2000);
      req_if(32'h0040_0300, lat_i);
    join
    n_checks++;
    if (last_if_seq - seq0 !== exp_pos) begin
      n_fail++;
      $display("FAIL starve_position: fetch served at %0d, expected %0d", last_if_seq - seq0, exp_pos);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    ack_dly = 5;
    rv_dly = 0;
    step();
    dm_req = 1'b1;
    dm_addr = 32'h8000_3000;
    repeat (2) step();
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: mem_req=%b, expected 1", mem_req);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    dm_req = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: req=%b addr=%h ifv=%b dmv=%b, expected all 0",
               mem_req, mem_addr, if_rvalid, dm_rvalid);
    end
    grant_q.delete();
    resp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    ack_dly = 0;
    exp_grant(1'b1, 32'h8000_3040);
    exp_resp(1'b1, mem_data(32'h8000_3040));
    req_dm(32'h8000_3040, lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL rstmid_fresh: lat=%0d, expected 3", lat);
    end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_flush();
    test_back_to_back();
    test_starve();
    test_reset_mid();
    repeat (4) step();
    n_checks++;
    if (grant_q.size() != 0 || resp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: grants left=%0d responses left=%0d, expected 0/0", grant_q.size(), resp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
